// File: rtl/jtag_tap_core_if.sv
// jtag_tap_core_if
// Bundles the JTAG pin-side signals (tms, tdi, tdo, tdo_en) and the
// chain-side signals (reset, instr, dr_sel, ext_tdo and the five DR/IR strobes)
// of the TAP core. tck and trst stay plain ports on the core.
//   master : the TAP core. It samples tms, tdi and ext_tdo and drives everything else.
//   slave  : the pads and the external data chains.
interface jtag_tap_core_if #(
   parameter int IR_WIDTH = 5,
   parameter int NUM_DR   = 4
);
   logic                tms;
   logic                tdi;
   logic                tdo;
   logic                tdo_en;
   logic                reset;
   logic [IR_WIDTH-1:0] instr;
   logic [NUM_DR-1:0]   dr_sel;
   logic [NUM_DR-1:0]   ext_tdo;
   logic                captureDR;
   logic                shiftDR;
   logic                updateDR;
   logic                captureIR;
   logic                updateIR;

   modport master (
      input  tms, tdi, ext_tdo,
      output tdo, tdo_en, reset, instr, dr_sel,
             captureDR, shiftDR, updateDR, captureIR, updateIR
   );

   modport slave (
      output tms, tdi, ext_tdo,
      input  tdo, tdo_en, reset, instr, dr_sel,
             captureDR, shiftDR, updateDR, captureIR, updateIR
   );
endinterface

// File: rtl/jtag_tap_core.sv
// jtag_tap_core
// 1149.1 TAP controller with an integrated instruction register, IDCODE and
// BYPASS registers, user-DR select decode, and a registered TDO mux.
// Ports:
//   tck  : test clock. The FSM and shift registers update on posedge.
//          Strobes, instr, dr_sel, reset and tdo update on negedge.
//   trst : asynchronous active-low reset.
//   tap  : jtag_tap_core_if.master. It carries the pin and chain signals.
module jtag_tap_core #(
   parameter int          IR_WIDTH   = 5,
   parameter int          NUM_DR     = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
   parameter int          IDCODE_OP  = 1,
   parameter int          USER_BASE  = 2
) (
   input logic             tck,
   input logic             trst,
   jtag_tap_core_if.master tap
);

   typedef enum logic [3:0] {
      stTestLogicReset = 4'd0,  stRunTestIdle = 4'd1,
      stSelectDrScan   = 4'd2,  stCaptureDr   = 4'd3,
      stShiftDr        = 4'd4,  stExit1Dr     = 4'd5,
      stPauseDr        = 4'd6,  stExit2Dr     = 4'd7,
      stUpdateDr       = 4'd8,  stSelectIrScan = 4'd9,
      stCaptureIr      = 4'd10, stShiftIr     = 4'd11,
      stExit1Ir        = 4'd12, stPauseIr     = 4'd13,
      stExit2Ir        = 4'd14, stUpdateIr    = 4'd15
   } tapState_t;

   // The captured IR value has its LSB set so that a broken chain is easy to see.
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
   localparam logic [IR_WIDTH-1:0] ID_OP      = IR_WIDTH'(IDCODE_OP);

   tapState_t           stateR, nextStateS;
   logic [IR_WIDTH-1:0] irSrR;
   logic [31:0]         idRegR;
   logic                bypassR;
   logic [IR_WIDTH-1:0] instrR;
   logic [NUM_DR-1:0]   drSelR;
   logic                tdoR, tdoEnR, resetR;
   logic                captureDrR, shiftDrR, updateDrR, captureIrR, updateIrR;
   logic                idSelS, tdoNextS;

   // One-hot user DR select for opcodes USER_BASE .. USER_BASE+NUM_DR-1.
   function automatic logic [NUM_DR-1:0] decodeSel(input logic [IR_WIDTH-1:0] op);
      logic [NUM_DR-1:0] sel;
      sel = '0;
      for (int k = 0; k < NUM_DR; k++) begin
         sel[k] = (op == IR_WIDTH'(USER_BASE + k));
      end
      return sel;
   endfunction

   assign idSelS = (instrR == ID_OP);

   // Standard 1149.1 TMS-driven next-state logic.
   always_comb begin
      nextStateS = stateR;
      case (stateR)
         stTestLogicReset: nextStateS = tap.tms ? stTestLogicReset : stRunTestIdle;
         stRunTestIdle:    nextStateS = tap.tms ? stSelectDrScan   : stRunTestIdle;
         stSelectDrScan:   nextStateS = tap.tms ? stSelectIrScan   : stCaptureDr;
         stCaptureDr:      nextStateS = tap.tms ? stExit1Dr        : stShiftDr;
         stShiftDr:        nextStateS = tap.tms ? stExit1Dr        : stShiftDr;
         stExit1Dr:        nextStateS = tap.tms ? stUpdateDr       : stPauseDr;
         stPauseDr:        nextStateS = tap.tms ? stExit2Dr        : stPauseDr;
         stExit2Dr:        nextStateS = tap.tms ? stUpdateDr       : stShiftDr;
         stUpdateDr:       nextStateS = tap.tms ? stSelectDrScan   : stRunTestIdle;
         stSelectIrScan:   nextStateS = tap.tms ? stTestLogicReset : stCaptureIr;
         stCaptureIr:      nextStateS = tap.tms ? stExit1Ir        : stShiftIr;
         stShiftIr:        nextStateS = tap.tms ? stExit1Ir        : stShiftIr;
         stExit1Ir:        nextStateS = tap.tms ? stUpdateIr       : stPauseIr;
         stPauseIr:        nextStateS = tap.tms ? stExit2Ir        : stPauseIr;
         stExit2Ir:        nextStateS = tap.tms ? stUpdateIr       : stShiftIr;
         stUpdateIr:       nextStateS = tap.tms ? stSelectDrScan   : stRunTestIdle;
         default:          nextStateS = stTestLogicReset;
      endcase
   end

   // State register and the posedge shift registers (IR, ID, bypass).
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         stateR  <= stTestLogicReset;
         irSrR   <= IR_CAPTURE;
         idRegR  <= IDCODE_VAL;
         bypassR <= 1'b0;
      end else begin
         stateR <= nextStateS;
         case (stateR)
            stCaptureIr: irSrR <= IR_CAPTURE;
            stShiftIr:   irSrR <= {tap.tdi, irSrR[IR_WIDTH-1:1]};
            stCaptureDr: begin
               bypassR <= 1'b0;
               if (idSelS) idRegR <= IDCODE_VAL;
            end
            stShiftDr: begin
               bypassR <= tap.tdi;
               if (idSelS) idRegR <= {tap.tdi, idRegR[31:1]};
            end
            default: ;
         endcase
      end
   end

   // TDO source select. This logic sees the pre-shift value of the register, so the first Shift-DR cycle presents bit 0.
   always_comb begin
      tdoNextS = 1'b0;
      if (stateR == stShiftIr) begin
         tdoNextS = irSrR[0];
      end else if (stateR == stShiftDr) begin
         if (idSelS)              tdoNextS = idRegR[0];
         else if (drSelR != '0)   tdoNextS = |(tap.ext_tdo & drSelR);
         else                     tdoNextS = bypassR;
      end else begin
         tdoNextS = 1'b0;
      end
   end

   // Negedge outputs: strobes, reset, instruction, select and the TDO pad.
   always_ff @(negedge tck or negedge trst) begin
      if (!trst) begin
         instrR     <= ID_OP;
         drSelR     <= '0;
         tdoR       <= 1'b0;
         tdoEnR     <= 1'b0;
         resetR     <= 1'b0;
         captureDrR <= 1'b0;
         shiftDrR   <= 1'b0;
         updateDrR  <= 1'b0;
         captureIrR <= 1'b0;
         updateIrR  <= 1'b0;
      end else begin
         tdoR       <= tdoNextS;
         tdoEnR     <= (stateR == stShiftIr) || (stateR == stShiftDr);
         resetR     <= (stateR != stTestLogicReset);
         captureDrR <= (stateR == stCaptureDr);
         shiftDrR   <= (stateR == stShiftDr);
         updateDrR  <= (stateR == stUpdateDr);
         captureIrR <= (stateR == stCaptureIr);
         updateIrR  <= (stateR == stUpdateIr);
         if (stateR == stUpdateIr) begin
            instrR <= irSrR;
            drSelR <= decodeSel(irSrR);
         end else if (stateR == stTestLogicReset) begin
            instrR <= ID_OP;
            drSelR <= '0;
         end else begin
            instrR <= instrR;
            drSelR <= drSelR;
         end
      end
   end

   assign tap.tdo       = tdoR;
   assign tap.tdo_en    = tdoEnR;
   assign tap.reset     = resetR;
   assign tap.instr     = instrR;
   assign tap.dr_sel    = drSelR;
   assign tap.captureDR = captureDrR;
   assign tap.shiftDR   = shiftDrR;
   assign tap.updateDR  = updateDrR;
   assign tap.captureIR = captureIrR;
   assign tap.updateIR  = updateIrR;

endmodule

// File: tb/tb_jtag_tap_core.sv
// tb_jtag_tap_core
// Directed bench for jtag_tap_core. Each step drives tms/tdi, then waits for a
// posedge and the following negedge. Outputs are sampled 1 time unit after that negedge.
module tb_jtag_tap_core;

   localparam int          IRW = 5;
   localparam int          NDR = 4;
   localparam logic [31:0] ID  = 32'h1234_5679;

   logic tck  = 1'b0;
   logic trst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   jtag_tap_core_if #(.IR_WIDTH(IRW), .NUM_DR(NDR)) tap ();

   jtag_tap_core #(
      .IR_WIDTH(IRW), .NUM_DR(NDR), .IDCODE_VAL(ID), .IDCODE_OP(1), .USER_BASE(2)
   ) dut (
      .tck  (tck),
      .trst (trst),
      .tap  (tap)
   );

   // Free-running test clock with a period of 10 time units.
   always #5 tck = ~tck;

   // Watchdog against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic tmsV, input logic tdiV);
      tap.tms = tmsV;
      tap.tdi = tdiV;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   // From Run-Test/Idle: shift val into the IR, update it and return to Run-Test/Idle.
   task automatic loadIr(input logic [IRW-1:0] val);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("captureIR", tap.captureIR, 1);
      step(1'b0, 1'b0);
      for (int i = 0; i < IRW; i++) step(i == IRW - 1, val[i]);
      step(1'b1, 1'b0);
      check("updateIR", tap.updateIR, 1);
      check("instr_load", tap.instr, val);
      step(1'b0, 1'b0);
   endtask

   initial begin
      tap.tms = 1'b1;
      tap.tdi = 1'b0;
      tap.ext_tdo = '0;

      // Reset state while trst is held low.
      #12;
      check("rst_reset", tap.reset, 0);
      check("rst_tdo", tap.tdo, 0);
      check("rst_tdo_en", tap.tdo_en, 0);
      check("rst_instr", tap.instr, 1);
      check("rst_dr_sel", tap.dr_sel, 0);
      check("rst_strobes", {tap.captureDR, tap.shiftDR, tap.updateDR,
                            tap.captureIR, tap.updateIR}, 0);
      @(negedge tck); #1;
      trst = 1'b1;

      // IDCODE read: tms 0,1,0,0, followed by 32 shift cycles.
      step(1'b0, 1'b0);
      check("rti_reset_high", tap.reset, 1);
      check("rti_tdo_en", tap.tdo_en, 0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("capDR_strobe", tap.captureDR, 1);
      check("capDR_no_shift", tap.shiftDR, 0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         if (i > 0) step(1'b0, 1'b0);
         check($sformatf("id_bit%0d", i), tap.tdo, ID[i]);
         check("id_tdo_en", tap.tdo_en, 1);
      end
      step(1'b1, 1'b0);
      check("exit1_tdo_en", tap.tdo_en, 0);
      check("exit1_tdo", tap.tdo, 0);
      step(1'b1, 1'b0);
      check("updDR_strobe", tap.updateDR, 1);
      step(1'b0, 1'b0);

      // IR capture: shift five ones and expect tdo to show 1,0,0,0,0.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("ircap_strobe", tap.captureIR, 1);
      step(1'b0, 1'b0);
      check("ir_tdo0", tap.tdo, 1);
      check("ir_tdo_en", tap.tdo_en, 1);
      for (int i = 1; i < 5; i++) begin
         step(1'b0, 1'b1);
         check($sformatf("ir_tdo%0d", i), tap.tdo, 0);
      end
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      check("ir_instr_1F", tap.instr, 5'h1F);
      check("ir_dr_sel_0", tap.dr_sel, 0);
      step(1'b0, 1'b0);

      // Bypass: shift 1,0,1,1 and expect tdo to show 0,1,0,1.
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("byp_tdo0", tap.tdo, 0);
      step(1'b0, 1'b1);
      check("byp_tdo1", tap.tdo, 1);
      step(1'b0, 1'b0);
      check("byp_tdo2", tap.tdo, 0);
      step(1'b0, 1'b1);
      check("byp_tdo3", tap.tdo, 1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);

      // User DR 1 (opcode 3). The other ext_tdo bits carry the opposite value.
      loadIr(5'd3);
      check("user_dr_sel", tap.dr_sel, 4'b0010);
      step(1'b1, 1'b0);
      tap.ext_tdo = 4'b1101;
      step(1'b0, 1'b0);
      check("user_capDR", tap.captureDR, 1);
      tap.ext_tdo = 4'b0010;
      step(1'b0, 1'b0);
      check("user_tdo0", tap.tdo, 1);
      check("user_shiftDR", tap.shiftDR, 1);
      step(1'b0, 1'b0);
      check("user_tdo1", tap.tdo, 1);
      tap.ext_tdo = 4'b1101;
      step(1'b0, 1'b0);
      check("user_tdo2", tap.tdo, 0);
      check("user_sel_stable", tap.dr_sel, 4'b0010);
      step(1'b1, 1'b0);
      check("user_exit_noshift", tap.shiftDR, 0);
      check("user_exit_noupd", tap.updateDR, 0);
      step(1'b1, 1'b0);
      check("user_updDR", tap.updateDR, 1);
      step(1'b0, 1'b0);
      tap.ext_tdo = '0;

      // TMS reset: from Pause-DR, apply five TMS=1 clocks.
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("pause_tdo_en", tap.tdo_en, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("tms4_reset_high", tap.reset, 1);
      step(1'b1, 1'b0);
      check("tms5_reset_low", tap.reset, 0);
      check("tms5_instr", tap.instr, 1);
      check("tms5_dr_sel", tap.dr_sel, 0);
      step(1'b0, 1'b0);

      // Async reset asserted during the third Shift-IR cycle.
      loadIr(5'h1F);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("abort_pre_tdo_en", tap.tdo_en, 1);
      trst = 1'b0;
      #1;
      check("abort_tdo", tap.tdo, 0);
      check("abort_tdo_en", tap.tdo_en, 0);
      check("abort_reset", tap.reset, 0);
      check("abort_instr", tap.instr, 1);
      @(negedge tck); #1;
      trst = 1'b1;
      step(1'b1, 1'b0);
      check("post_abort_instr", tap.instr, 1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("post_abort_id0", tap.tdo, ID[0]);
      step(1'b0, 1'b0);
      check("post_abort_id1", tap.tdo, ID[1]);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
